// File: rtl/cdb_arbiter_if.sv
// Producer-side result inputs plus CDB broadcast and regfile writeback lanes of cdb_arbiter.
// Channel c / lane l occupy slice [c*W +: W] / [l*W +: W] of each bus.
interface cdb_arbiter_if #(
    parameter int NUM_CH  = 3,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32
) ();
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_ready;
    logic [NUM_CH*TAG_W-1:0]   in_tag;
    logic [NUM_CH*5-1:0]       in_dest;
    logic [NUM_CH*XLEN-1:0]    in_result;
    logic [NUM_CH*XLEN-1:0]    in_pc;
    logic [NUM_CH-1:0]         in_take_branch;

    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*5-1:0]      cdb_dest;
    logic [NUM_CDB*XLEN-1:0]   cdb_value;
    logic [NUM_CDB-1:0]        cdb_take_branch;
    logic [NUM_CDB*XLEN-1:0]   cdb_alu_result;
    logic [NUM_CDB-1:0]        wb_en;
    logic [NUM_CDB*5-1:0]      wb_idx;
    logic [NUM_CDB*XLEN-1:0]   wb_data;

    modport master (
        output in_valid, in_tag, in_dest, in_result, in_pc, in_take_branch,
        input  in_ready,
        input  cdb_valid, cdb_tag, cdb_dest, cdb_value, cdb_take_branch, cdb_alu_result,
        input  wb_en, wb_idx, wb_data
    );

    modport slave (
        input  in_valid, in_tag, in_dest, in_result, in_pc, in_take_branch,
        output in_ready,
        output cdb_valid, cdb_tag, cdb_dest, cdb_value, cdb_take_branch, cdb_alu_result,
        output wb_en, wb_idx, wb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-channel result FIFOs drained round-robin onto NUM_CDB CDB/writeback lanes.
// Latency 1 cycle accept->broadcast; in_ready low when a FIFO is full or during flush/reset.
module cdb_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int NUM_CDB = 2,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [4:0]       dest;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  pc;
        logic             take_branch;
    } entry_t;

    entry_t             mem_q    [NUM_CH][DEPTH];
    entry_t             mem_d    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]   count_q  [NUM_CH];
    logic [CNT_W-1:0]   count_d  [NUM_CH];
    logic [CH_W-1:0]    rr_ptr_q;
    logic [CH_W-1:0]    rr_ptr_d;

    logic               active;
    logic [NUM_CH-1:0]  ready;
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  pop;
    entry_t             head     [NUM_CH];
    logic [NUM_CDB-1:0] lane_vld;
    entry_t             lane_ent [NUM_CDB];
    logic [XLEN-1:0]    lane_val [NUM_CDB];

    assign active       = !reset && !flush;
    assign bus.in_ready = ready;

    always_comb begin
        ready = '0;
        push  = '0;
        mem_d = mem_q;
        head  = '{default: '0};
        for (int c = 0; c < NUM_CH; c++) begin
            ready[c] = active && (count_q[c] < CNT_W'(DEPTH));
            push[c]  = bus.in_valid[c] && ready[c];
            head[c]  = mem_q[c][rd_ptr_q[c]];
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = '{tag:         bus.in_tag[c*TAG_W +: TAG_W],
                                          dest:        bus.in_dest[c*5 +: 5],
                                          result:      bus.in_result[c*XLEN +: XLEN],
                                          pc:          bus.in_pc[c*XLEN +: XLEN],
                                          take_branch: bus.in_take_branch[c]};
            end
        end
    end

    // Scan from rr_ptr with wrap; lanes fill in scan order, one entry per channel.
    always_comb begin
        logic [CH_W:0]   idx_w;
        logic [CH_W:0]   nxt_w;
        logic [CH_W-1:0] idx;
        int              n_gnt;
        pop      = '0;
        lane_vld = '0;
        lane_ent = '{default: '0};
        rr_ptr_d = rr_ptr_q;
        idx_w    = '0;
        nxt_w    = '0;
        idx      = '0;
        n_gnt    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            if (idx_w >= (CH_W+1)'(NUM_CH)) begin
                idx_w = idx_w - (CH_W+1)'(NUM_CH);
            end
            idx = idx_w[CH_W-1:0];
            if (active && (count_q[idx] != '0) && (n_gnt < NUM_CDB)) begin
                pop[idx] = 1'b1;
                for (int l = 0; l < NUM_CDB; l++) begin
                    if (l == n_gnt) begin
                        lane_vld[l] = 1'b1;
                        lane_ent[l] = head[idx];
                    end
                end
                n_gnt    = n_gnt + 1;
                nxt_w    = {1'b0, idx} + (CH_W+1)'(1);
                rr_ptr_d = (nxt_w == (CH_W+1)'(NUM_CH)) ? '0 : nxt_w[CH_W-1:0];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
            count_d[c]  = count_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            if (flush) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            count_q  <= '{default: '0};
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
        mem_q <= mem_d;
    end

    // Idle lanes carry an all-zero entry, so every lane field reads 0 without extra gating.
    always_comb begin
        bus.cdb_valid       = '0;
        bus.cdb_tag         = '0;
        bus.cdb_dest        = '0;
        bus.cdb_value       = '0;
        bus.cdb_take_branch = '0;
        bus.cdb_alu_result  = '0;
        bus.wb_en           = '0;
        bus.wb_idx          = '0;
        bus.wb_data         = '0;
        lane_val            = '{default: '0};
        for (int l = 0; l < NUM_CDB; l++) begin
            lane_val[l] = lane_ent[l].take_branch ? (lane_ent[l].pc + XLEN'(4)) : lane_ent[l].result;
            bus.cdb_valid[l]                   = lane_vld[l];
            bus.cdb_tag[l*TAG_W +: TAG_W]      = lane_ent[l].tag;
            bus.cdb_dest[l*5 +: 5]             = lane_ent[l].dest;
            bus.cdb_value[l*XLEN +: XLEN]      = lane_val[l];
            bus.cdb_take_branch[l]             = lane_vld[l] && lane_ent[l].take_branch;
            bus.cdb_alu_result[l*XLEN +: XLEN] = lane_ent[l].result;
            bus.wb_en[l]                       = lane_vld[l] && (lane_ent[l].dest != 5'd0);
            bus.wb_idx[l*5 +: 5]               = lane_ent[l].dest;
            bus.wb_data[l*XLEN +: XLEN]        = lane_val[l];
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus random stimulus for cdb_arbiter, checked against a queue-per-channel reference.
module tb_cdb_arbiter;
    localparam int NCH   = 3;
    localparam int NCDB  = 2;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [4:0]  tag;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic        tb;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_CH(NCH), .NUM_CDB(NCDB), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

    cdb_arbiter #(.NUM_CH(NCH), .NUM_CDB(NCDB), .DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    ent_t           mq [NCH][$];
    int             rr;
    int             g_ch [$];
    logic [NCH-1:0] e_ready;
    int             passes;
    int             checks;
    int             dut_cnt [NCH];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) passes++;
        else $error("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic set_ch(input int c, input logic v, input logic [4:0] tag, input logic [4:0] dest,
                          input logic [31:0] res, input logic [31:0] pc, input logic tbr);
        bus.in_valid[c]          = v;
        bus.in_tag[c*5 +: 5]     = tag;
        bus.in_dest[c*5 +: 5]    = dest;
        bus.in_result[c*32 +: 32] = res;
        bus.in_pc[c*32 +: 32]    = pc;
        bus.in_take_branch[c]    = tbr;
    endtask

    task automatic idle();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic ent_t in_ent(input int c);
        ent_t e;
        e.tag    = bus.in_tag[c*5 +: 5];
        e.dest   = bus.in_dest[c*5 +: 5];
        e.result = bus.in_result[c*32 +: 32];
        e.pc     = bus.in_pc[c*32 +: 32];
        e.tb     = bus.in_take_branch[c];
        return e;
    endfunction

    // Predict this cycle's outputs from the model queues and compare every output bus.
    task automatic settle(input string name);
        logic [NCDB-1:0]      ev, etb, ewe;
        logic [NCDB*5-1:0]    etag, edest;
        logic [NCDB*32-1:0]   eval, ealu;
        ent_t                 e;
        int                   ch;
        int                   l;
        #1;
        g_ch.delete();
        ev = '0; etb = '0; ewe = '0; etag = '0; edest = '0; eval = '0; ealu = '0;
        for (int c = 0; c < NCH; c++) e_ready[c] = !reset && !flush && (mq[c].size() < DEPTH);
        if (!reset && !flush) begin
            for (int k = 0; k < NCH; k++) begin
                ch = (rr + k) % NCH;
                if (mq[ch].size() > 0 && g_ch.size() < NCDB) begin
                    l = g_ch.size();
                    e = mq[ch][0];
                    ev[l]             = 1'b1;
                    etb[l]            = e.tb;
                    ewe[l]            = (e.dest != 0);
                    etag[l*5 +: 5]    = e.tag;
                    edest[l*5 +: 5]   = e.dest;
                    eval[l*32 +: 32]  = e.tb ? e.pc + 32'd4 : e.result;
                    ealu[l*32 +: 32]  = e.result;
                    g_ch.push_back(ch);
                end
            end
        end
        chk({name, ".in_ready"},   64'(bus.in_ready),        64'(e_ready));
        chk({name, ".cdb_valid"},  64'(bus.cdb_valid),       64'(ev));
        chk({name, ".cdb_tag"},    64'(bus.cdb_tag),         64'(etag));
        chk({name, ".cdb_dest"},   64'(bus.cdb_dest),        64'(edest));
        chk({name, ".cdb_value"},  64'(bus.cdb_value),       64'(eval));
        chk({name, ".cdb_tb"},     64'(bus.cdb_take_branch), 64'(etb));
        chk({name, ".cdb_alu"},    64'(bus.cdb_alu_result),  64'(ealu));
        chk({name, ".wb_en"},      64'(bus.wb_en),           64'(ewe));
        chk({name, ".wb_idx"},     64'(bus.wb_idx),          64'(edest));
        chk({name, ".wb_data"},    64'(bus.wb_data),         64'(eval));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            rr = 0;
        end else if (flush) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
        end else begin
            foreach (g_ch[i]) void'(mq[g_ch[i]].pop_front());
            if (g_ch.size() > 0) rr = (g_ch[g_ch.size()-1] + 1) % NCH;
            for (int c = 0; c < NCH; c++)
                if (bus.in_valid[c] && e_ready[c]) mq[c].push_back(in_ent(c));
        end
        @(negedge clock);
    endtask

    int exp_l0 [3] = '{0, 2, 1};
    int exp_l1 [3] = '{1, 0, 2};

    initial begin
        passes = 0;
        checks = 0;
        rr     = 0;
        for (int c = 0; c < NCH; c++) dut_cnt[c] = 0;
        idle();
        reset = 1'b1;
        @(negedge clock);
        settle("reset0");
        chk("reset.in_ready", 64'(bus.in_ready), 64'(3'b000));
        tick();
        reset = 1'b0;
        settle("post_reset");
        chk("post_reset.in_ready", 64'(bus.in_ready), 64'(3'b111));
        tick();

        // Single push on ch0, broadcast on the next cycle in lane 0.
        set_ch(0, 1'b1, 5'd3, 5'd5, 32'h1234, 32'h0, 1'b0);
        settle("push0");
        chk("push0.same_cycle_valid", 64'(bus.cdb_valid), 64'(2'b00));
        tick();
        idle();
        settle("push0_bc");
        chk("push0.valid", 64'(bus.cdb_valid), 64'(2'b01));
        chk("push0.tag",   64'(bus.cdb_tag[4:0]), 64'(5'd3));
        chk("push0.value", 64'(bus.cdb_value[31:0]), 64'(32'h1234));
        chk("push0.wb_en", 64'(bus.wb_en), 64'(2'b01));
        chk("push0.wb_idx", 64'(bus.wb_idx[4:0]), 64'(5'd5));
        tick();

        // Jump on ch1: link value pc+4, raw result carried separately.
        set_ch(1, 1'b1, 5'd7, 5'd1, 32'h200, 32'h100, 1'b1);
        settle("jump");
        tick();
        idle();
        settle("jump_bc");
        chk("jump.value",   64'(bus.cdb_value[31:0]), 64'(32'h104));
        chk("jump.wb_data", 64'(bus.wb_data[31:0]), 64'(32'h104));
        chk("jump.alu",     64'(bus.cdb_alu_result[31:0]), 64'(32'h200));
        chk("jump.tb",      64'(bus.cdb_take_branch), 64'(2'b01));
        tick();

        // PC wrap and dest=0 on ch2.
        set_ch(2, 1'b1, 5'd9, 5'd0, 32'h55, 32'hFFFF_FFFC, 1'b1);
        settle("wrap");
        tick();
        idle();
        settle("wrap_bc");
        chk("dest0.valid", 64'(bus.cdb_valid), 64'(2'b01));
        chk("dest0.wb_en", 64'(bus.wb_en), 64'(2'b00));
        chk("wrap.value",  64'(bus.cdb_value[31:0]), 64'(32'h0));
        tick();

        // All channels busy: grant order and ch2 backpressure.
        for (int t = 0; t <= 6; t++) begin
            for (int c = 0; c < NCH; c++)
                set_ch(c, 1'b1, 5'(c*8 + t), 5'(c + 1), 32'(t*16 + c), 32'h1000, 1'b0);
            settle("rr");
            if (t >= 1 && t <= 3) begin
                chk("rr.lane0_ch", 64'(bus.cdb_tag[4:3]), 64'(exp_l0[t-1]));
                chk("rr.lane1_ch", 64'(bus.cdb_tag[9:8]), 64'(exp_l1[t-1]));
            end
            if (t == 2) chk("bp.ch2_full",  64'(bus.in_ready[2]), 64'(1'b0));
            if (t == 3) chk("bp.ch2_ready", 64'(bus.in_ready[2]), 64'(1'b1));
            if (t >= 1) begin
                for (int l = 0; l < NCDB; l++)
                    if (bus.cdb_valid[l]) dut_cnt[bus.cdb_tag[l*5+3 +: 2]]++;
            end
            tick();
        end
        for (int c = 0; c < NCH; c++) chk("rr.fair", 64'(dut_cnt[c]), 64'(4));

        // Flush with buffered entries.
        flush = 1'b1;
        settle("flush");
        chk("flush.valid", 64'(bus.cdb_valid), 64'(2'b00));
        chk("flush.wb_en", 64'(bus.wb_en), 64'(2'b00));
        tick();
        flush = 1'b0;
        idle();
        settle("post_flush");
        chk("post_flush.ready", 64'(bus.in_ready), 64'(3'b111));
        chk("post_flush.valid", 64'(bus.cdb_valid), 64'(2'b00));
        tick();

        // Reset in the middle of a burst.
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < NCH; c++)
                set_ch(c, 1'b1, 5'(c + 20), 5'(c + 9), 32'(c * 3), 32'h40, 1'b0);
            settle("burst");
            tick();
        end
        reset = 1'b1;
        settle("mid_reset");
        tick();
        reset = 1'b0;
        idle();
        for (int t = 0; t < 2; t++) begin
            settle("after_reset");
            chk("after_reset.valid", 64'(bus.cdb_valid), 64'(2'b00));
            tick();
        end

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++)
                set_ch(c, ($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom_range(0, 31)),
                       $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                       1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 63) == 0);
            settle("rand");
            tick();
        end
        flush = 1'b0;
        reset = 1'b0;
        idle();
        for (int t = 0; t < 4; t++) begin
            settle("drain");
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
